// File: rtl/pkt_rx_pkg.sv
// Shared types and header field layout for the egress packet receiver.
package pkt_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } rx_state_t;

    localparam int DST_MSB = 31;
    localparam int DST_LSB = 24;
    localparam int SRC_MSB = 23;
    localparam int SRC_LSB = 16;
    localparam int LEN_MSB = 15;
    localparam int LEN_LSB = 0;

    typedef struct packed {
        logic [7:0]  dst;
        logic [7:0]  src;
        logic [15:0] len;
    } pkt_hdr_t;

endpackage

// File: rtl/pkt_rx_buf.sv
// Store-and-forward word buffer: speculative write pointer, commit pointer
// and show-ahead read port. Uncommitted words are invisible to the reader.
module pkt_rx_buf #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [33:0] wr_word,
    input  logic        commit,
    input  logic        rewind,
    input  logic        rd_ready,
    output logic        full,
    output logic        full_cm,
    output logic        rd_valid,
    output logic [33:0] rd_word
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [33:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] cm_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_base;

    // A rewind in the same cycle as a write restarts the packet at the commit point.
    assign wr_base  = rewind ? cm_ptr : wr_ptr;
    assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
    assign full_cm  = (cm_ptr - rd_ptr) == DEPTH_P;
    assign rd_valid = cm_ptr != rd_ptr;
    assign rd_word  = rd_valid ? mem[rd_ptr[AW-1:0]] : 34'd0;

    // Pointer update: write, commit/rewind and read advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rewind || wr_en) begin
                wr_ptr <= wr_base + PW'(wr_en);
            end
            if (commit) begin
                cm_ptr <= wr_base + PW'(1);
            end
            if (rd_valid && rd_ready) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage array; contents need no reset because reads are gated by rd_valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_base[AW-1:0]] <= wr_word;
        end
    end

endmodule

// File: rtl/pkt_rx_port.sv
// Egress packet receiver: validates framing/header, buffers good packets whole,
// streams them out over valid/ready and keeps receive statistics.
module pkt_rx_port
    import pkt_rx_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [7:0]  PORT_ADDR = 8'h00,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inData,
    input  logic             inSop,
    input  logic             inEop,
    output logic [31:0]      rdData,
    output logic             rdSop,
    output logic             rdEop,
    output logic             rdValid,
    input  logic             rdReady,
    output logic [CNT_W-1:0] pktCount,
    output logic [CNT_W-1:0] errCount,
    output logic [CNT_W-1:0] dropCount
);

    rx_state_t   state;
    rx_state_t   nxt;
    logic [15:0] remaining;
    logic [7:0]  hdr_dst;
    logic [15:0] hdr_len;
    logic        len_bad;
    logic        take_sop;
    logic        wr_en;
    logic        commit;
    logic        rewind;
    logic        full;
    logic        full_cm;
    logic        inc_pkt;
    logic        inc_err;
    logic        inc_drop;
    logic        rem_load;
    logic        rem_dec;
    logic [33:0] rd_word;

    assign hdr_dst = inData[DST_MSB:DST_LSB];
    assign hdr_len = inData[LEN_MSB:LEN_LSB];
    assign len_bad = (hdr_len == 16'd0) || ((32'(hdr_len) + 32'd1) > 32'(DEPTH));

    // Next-state and buffer-control decode for the receive FSM.
    always_comb begin
        nxt      = state;
        take_sop = 1'b0;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rewind   = 1'b0;
        inc_pkt  = 1'b0;
        inc_err  = 1'b0;
        inc_drop = 1'b0;
        rem_load = 1'b0;
        rem_dec  = 1'b0;
        case (state)
            IDLE: begin
                take_sop = inSop;
                if (!inSop && inEop) begin
                    inc_err = 1'b1;
                end else begin
                    inc_err = 1'b0;
                end
            end
            RECV: begin
                if (inSop) begin
                    inc_err  = 1'b1;
                    rewind   = 1'b1;
                    take_sop = 1'b1;
                end else if (full) begin
                    rewind   = 1'b1;
                    inc_drop = 1'b1;
                    nxt      = inEop ? IDLE : DROP;
                end else if (inEop) begin
                    if (remaining == 16'd1) begin
                        wr_en   = 1'b1;
                        commit  = 1'b1;
                        inc_pkt = 1'b1;
                    end else begin
                        rewind  = 1'b1;
                        inc_err = 1'b1;
                    end
                    nxt = IDLE;
                end else if (remaining == 16'd1) begin
                    // Header length already satisfied but no eop: overlong packet.
                    inc_err = 1'b1;
                    rewind  = 1'b1;
                    nxt     = DROP;
                end else begin
                    wr_en   = 1'b1;
                    rem_dec = 1'b1;
                end
            end
            DROP: begin
                if (inSop) begin
                    take_sop = 1'b1;
                end else if (inEop) begin
                    nxt = IDLE;
                end else begin
                    nxt = DROP;
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase

        // Header handling shared by IDLE, DROP and a restart inside RECV.
        if (take_sop) begin
            if (inEop) begin
                inc_err = 1'b1;
                nxt     = IDLE;
            end else if (hdr_dst != PORT_ADDR) begin
                inc_drop = 1'b1;
                nxt      = DROP;
            end else if (len_bad) begin
                inc_err = 1'b1;
                nxt     = DROP;
            end else if (full_cm) begin
                inc_drop = 1'b1;
                nxt      = DROP;
            end else begin
                wr_en    = 1'b1;
                rem_load = 1'b1;
                nxt      = RECV;
            end
        end else begin
            rem_load = 1'b0;
        end
    end

    // FSM state, remaining-word count and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= 16'd0;
            pktCount  <= '0;
            errCount  <= '0;
            dropCount <= '0;
        end else begin
            state <= nxt;
            if (rem_load) begin
                remaining <= hdr_len;
            end else if (rem_dec) begin
                remaining <= remaining - 16'd1;
            end
            if (inc_pkt) begin
                pktCount <= pktCount + CNT_W'(1);
            end
            if (inc_err) begin
                errCount <= errCount + CNT_W'(1);
            end
            if (inc_drop) begin
                dropCount <= dropCount + CNT_W'(1);
            end
        end
    end

    pkt_rx_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_word ({inSop, inEop, inData}),
        .commit  (commit),
        .rewind  (rewind),
        .rd_ready(rdReady),
        .full    (full),
        .full_cm (full_cm),
        .rd_valid(rdValid),
        .rd_word (rd_word)
    );

    assign {rdSop, rdEop, rdData} = rd_word;

endmodule

// File: tb/tb_pkt_rx_port.sv
// Directed-vector bench for pkt_rx_port with a queue scoreboard and a
// separate output monitor.
module tb_pkt_rx_port;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inData;
    logic        inSop;
    logic        inEop;
    logic [31:0] rdData;
    logic        rdSop;
    logic        rdEop;
    logic        rdValid;
    logic        rdReady;
    logic [15:0] pktCount;
    logic [15:0] errCount;
    logic [15:0] dropCount;

    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] exp_q[$];

    pkt_rx_port #(
        .DEPTH    (DEPTH),
        .PORT_ADDR(8'h00),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inData   (inData),
        .inSop    (inSop),
        .inEop    (inEop),
        .rdData   (rdData),
        .rdSop    (rdSop),
        .rdEop    (rdEop),
        .rdValid  (rdValid),
        .rdReady  (rdReady),
        .pktCount (pktCount),
        .errCount (errCount),
        .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pops the scoreboard on every accepted output word.
    task automatic monitor_loop();
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rdValid === 1'b1 && rdReady === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", {rdSop, rdEop, rdData});
                end else begin
                    e = exp_q.pop_front();
                    check("rd_word", 64'({rdSop, rdEop, rdData}), 64'(e));
                end
            end
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e, input bit keep);
        inData = d;
        inSop  = s;
        inEop  = e;
        if (keep) exp_q.push_back({s, e, d});
        @(posedge clk);
        #1;
        inData = 32'd0;
        inSop  = 1'b0;
        inEop  = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input int npay, input bit keep);
        send(hdr, 1'b1, 1'b0, keep);
        for (int i = 0; i < npay; i++) begin
            send({hdr[23:16], 8'hA5, 16'(i + 1)}, 1'b0, (i == npay - 1), keep);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0 && rdValid == 1'b0) break;
            @(posedge clk);
            #1;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("drain_valid", 64'(rdValid), 64'd0);
    endtask

    task automatic check_cnt(input string tag, input int p, input int e, input int d);
        check({tag, "_pkt"}, 64'(pktCount), 64'(p));
        check({tag, "_err"}, 64'(errCount), 64'(e));
        check({tag, "_drop"}, 64'(dropCount), 64'(d));
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        rst = 1'b1; rdReady = 1'b0; inData = 32'd0; inSop = 1'b0; inEop = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", 64'(rdValid), 64'd0);
        check("rst_data", 64'({rdSop, rdEop, rdData}), 64'd0);
        check_cnt("rst", 0, 0, 0);
        rst = 1'b0;

        // 1: basic good packet, latency of rdValid
        rdReady = 1'b1;
        send(32'h0011_0003, 1'b1, 1'b0, 1'b1);
        send(32'h1111_0001, 1'b0, 1'b0, 1'b1);
        send(32'h1111_0002, 1'b0, 1'b0, 1'b1);
        check("t1_valid_before_eop", 64'(rdValid), 64'd0);
        send(32'h1111_0003, 1'b0, 1'b1, 1'b1);
        check("t1_valid_after_eop", 64'(rdValid), 64'd1);
        check("t1_sop_first", 64'(rdSop), 64'd1);
        wait_drain();
        check_cnt("t1", 1, 0, 0);

        // 2: short packet (eop early) is discarded
        send(32'h0000_0005, 1'b1, 1'b0, 1'b0);
        send(32'h2222_0001, 1'b0, 1'b0, 1'b0);
        send(32'h2222_0002, 1'b0, 1'b0, 1'b0);
        send(32'h2222_0003, 1'b0, 1'b1, 1'b0);
        send(32'd0, 1'b0, 1'b0, 1'b0);
        check("t2_no_output", 64'(rdValid), 64'd0);
        check_cnt("t2", 1, 1, 0);

        // 3: address miss then good packet
        send_pkt(32'h0700_0003, 3, 1'b0);
        send_pkt(32'h0022_0002, 2, 1'b1);
        wait_drain();
        check_cnt("t3", 2, 1, 1);

        // 4: fill the buffer with reader stalled
        rdReady = 1'b0;
        send_pkt(32'h00A1_0003, 3, 1'b1);
        send_pkt(32'h00A2_0003, 3, 1'b1);
        send_pkt(32'h00A3_0003, 3, 1'b0);
        check("t4_stalled_valid", 64'(rdValid), 64'd1);
        check_cnt("t4", 4, 1, 2);
        rdReady = 1'b1;
        wait_drain();
        send_pkt(32'h00BB_0001, 1, 1'b1);
        wait_drain();
        check_cnt("t4b", 5, 1, 2);

        // 5: sop mid-packet restarts with the new header
        send(32'h0033_0003, 1'b1, 1'b0, 1'b0);
        send(32'h3333_0001, 1'b0, 1'b0, 1'b0);
        send(32'h3333_0002, 1'b0, 1'b0, 1'b0);
        send_pkt(32'h0044_0002, 2, 1'b1);
        wait_drain();
        check_cnt("t5", 6, 2, 2);

        // 6: reset in the middle of a packet
        send(32'h0055_0003, 1'b1, 1'b0, 1'b0);
        send(32'h5555_0001, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_valid", 64'(rdValid), 64'd0);
        check("t6_rst_data", 64'({rdSop, rdEop, rdData}), 64'd0);
        check_cnt("t6_rst", 0, 0, 0);
        rst = 1'b0;
        send_pkt(32'h0066_0001, 1, 1'b1);
        wait_drain();
        check_cnt("t6", 1, 0, 0);

        // 7: runt, len=0, len too large, stray eop, overlong, max-size packet
        send(32'h0000_0001, 1'b1, 1'b1, 1'b0);
        check_cnt("t7_runt", 1, 1, 0);
        send(32'h0000_0000, 1'b1, 1'b0, 1'b0);
        send(32'h7777_0001, 1'b0, 1'b1, 1'b0);
        check_cnt("t7_len0", 1, 2, 0);
        send(32'h0000_0008, 1'b1, 1'b0, 1'b0);
        send(32'h7777_0002, 1'b0, 1'b1, 1'b0);
        check_cnt("t7_len8", 1, 3, 0);
        send(32'h7777_0003, 1'b0, 1'b1, 1'b0);
        check_cnt("t7_stray", 1, 4, 0);
        send(32'h0000_0001, 1'b1, 1'b0, 1'b0);
        send(32'h7777_0004, 1'b0, 1'b0, 1'b0);
        send(32'h7777_0005, 1'b0, 1'b1, 1'b0);
        check_cnt("t7_long", 1, 5, 0);
        send_pkt(32'h0077_0007, 7, 1'b1);
        wait_drain();
        check_cnt("t7", 2, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_rx_port.md
Name: pkt_rx_port

Overview:
Egress-side packet receiver that terminates one switch2x2 output port (outDataX/sopXo/eopXo). It validates framing and header, then stores each good packet in a store-and-forward buffer. It presents buffered packets to a downstream consumer over a valid/ready word stream, and keeps receive statistics. The switch output has no backpressure, so bad or unbufferable packets are discarded whole and never partially forwarded.

Parameters:
DEPTH, 64, buffer depth in 32-bit words; power of 2, minimum 4
PORT_ADDR, 8'h00, destination address this port accepts
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset: one clock; reset is synchronous and active-high
inData  input  32  word from switch output port
inSop  input  1  first word of packet (header)
inEop  input  1  last word of packet
rdData  output  32  buffered word to consumer
rdSop  output  1  rdData is a packet header
rdEop  output  1  rdData is the last word of a packet
rdValid  output  1  rdData/rdSop/rdEop valid
rdReady  input  1  consumer accepts the word when rdValid&rdReady
pktCount  output  CNT_W  committed good packets
errCount  output  CNT_W  framing/length errors
dropCount  output  CNT_W  address-miss plus overflow drops

Behaviour:
- Header word: [31:24]=dst, [23:16]=src, [15:0]=len (payload word count). A packet is the header plus len payload words. len=0 is illegal.
- A word is "present" when inSop, inEop, or the word lies between sop and eop. There is no valid strobe; the FSM decides which words are present.
- Buffer: DEPTH x 34 bits ({sop,eop,data}). Three pointers, each log2(DEPTH)+1 bits, wrapping mod 2*DEPTH:
  - wrPtr: speculative write position.
  - cmPtr: commit position.
  - rdPtr: read position.
- full = (wrPtr - rdPtr) == DEPTH.
- Commit sets cmPtr <= wrPtr + 1 in the eop cycle. Rewind sets wrPtr <= cmPtr.
- FSM states: IDLE, RECV, DROP.
- IDLE:
  - inSop & inEop -> errCount++ (runt), stay IDLE.
  - inSop with dst != PORT_ADDR -> dropCount++, go DROP.
  - inSop with len+1 > DEPTH, or len == 0 -> errCount++, go DROP.
  - inSop with full -> dropCount++, go DROP.
  - Otherwise write the header, load remaining = len, go RECV.
  - inEop without inSop -> errCount++. Any other word in IDLE is ignored.
- RECV, each cycle:
  - inSop -> errCount++, rewind, then reprocess this word exactly as IDLE would, in the same cycle.
  - full -> rewind, dropCount++, go DROP. If inEop is also set, go IDLE instead.
  - Else write the word and decrement remaining.
  - On inEop: if the word written is the last (remaining == 1) -> commit, pktCount++, go IDLE. Else rewind, errCount++, go IDLE.
  - Word with remaining == 1 and no eop -> errCount++, rewind, go DROP (overlong).
- DROP: discard words until inEop, then go IDLE. inSop in DROP is processed as in IDLE.
- Read side: rdValid = (cmPtr != rdPtr). rdData/rdSop/rdEop are combinational from mem[rdPtr] (show-ahead). rdPtr increments on rdValid & rdReady.
- Timing:
  - A committed packet's header is visible on rdValid the cycle after its eop.
  - Minimum throughput is 1 word/cycle in each direction.
  - Write and read in the same cycle are both legal. full is evaluated before that cycle's read.
- Counters wrap modulo 2^CNT_W. When two events coincide in one cycle, each affected counter increments by at most 1.
- Reset: all pointers, counters and remaining go to 0; FSM -> IDLE; rdValid=0, rdSop=0, rdEop=0, rdData=0 (mem contents are don't-care but output is gated to 0 when !rdValid). A partial packet interrupted by reset is discarded. The first word after reset deasserts is processed normally.

Decomposition:
- Package pkt_rx_pkg holds:
  - typedef rx_state_t {IDLE, RECV, DROP}
  - header field bit positions (DST_MSB/LSB, SRC_MSB/LSB, LEN_MSB/LSB)
  - typedef pkt_hdr_t as a packed struct {dst, src, len}
- Sub-module pkt_rx_buf: dual-pointer store-and-forward memory with commit/rewind inputs, full output and show-ahead read port. The FSM and counters stay in pkt_rx_port.

Test Plan:
1. After reset, send header 32'h0011_0003 + 3 data words, rdReady=1 -> rdValid rises the cycle after eop; 4 words out with rdSop on word 0 and rdEop on word 3; pktCount=1.
2. Header len=5, eop on the 3rd payload word -> nothing on rdValid; errCount=1; wrPtr==cmPtr==rdPtr.
3. Header dst=8'h07 with PORT_ADDR=8'h00, 4-word packet -> dropped; dropCount=1; next good packet forwards intact.
4. DEPTH=8, rdReady=0, three 4-word good packets -> first two commit (pktCount=2), third dropped (dropCount=1). Then rdReady=1 -> exactly 8 words out, then a new packet is accepted.
5. inSop mid-packet after 2 of 3 payload words, followed by a complete good packet -> errCount=1; only the second packet is delivered; pktCount=1.
6. Assert rst for 1 cycle during RECV, then send a good 2-word packet (len=1) -> all outputs 0 during reset; pktCount=1 afterwards; delivered words match.
